// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, default reset PC
// and the fetch state encoding.
package ifu_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_W             = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch stage: holds the PC, issues one fetch at a time over req/gnt/rvalid
// and hands {pc, inst} to decode over valid/ready. Redirects squash stale fetches.
module ifu
    import ifu_pkg::*;
#(
    parameter int               XLEN     = PC_W,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INST_W-1:0]  imem_rdata_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [INST_W-1:0]  inst_o
);

    ifu_state_e         state_q;
    logic [XLEN-1:0]    pc_q;
    logic [INST_W-1:0]  inst_q;
    logic               kill_q;

    logic [XLEN-1:0]    redirect_tgt;
    logic [XLEN-1:0]    pc_seq;

    // Targets are forced word-aligned; sequential PC wraps naturally at 2^XLEN.
    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
    assign pc_seq       = pc_q + XLEN'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_i) begin
                        pc_q <= redirect_tgt;
                    end else if (imem_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (redirect_i) begin
                            pc_q <= redirect_tgt;
                        end
                        if (kill_q || redirect_i) begin
                            state_q <= S_REQ;
                        end else begin
                            inst_q  <= imem_rdata_i;
                            state_q <= S_VALID;
                        end
                    end else if (redirect_i) begin
                        // Response still owed by memory; remember to drop it on arrival.
                        pc_q   <= redirect_tgt;
                        kill_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_tgt;
                        state_q <= S_REQ;
                    end else if (ready_i) begin
                        pc_q    <= pc_seq;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Suppress the request while redirecting so no fetch goes out with a stale address.
    assign imem_req_o  = (state_q == S_REQ) && !redirect_i;
    assign imem_addr_o = pc_q;
    assign valid_o     = (state_q == S_VALID);
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by randomized traffic checked
// against an architectural model of the expected PC stream and memory contents.
module tb_ifu;
    import ifu_pkg::*;

    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               imem_req_o;
    logic [XLEN-1:0]    imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [31:0]        imem_rdata_i;
    logic               redirect_i;
    logic [XLEN-1:0]    redirect_pc_i;
    logic               valid_o;
    logic               ready_i;
    logic [XLEN-1:0]    pc_o;
    logic [31:0]        inst_o;

    int tests_run    = 0;
    int tests_failed = 0;

    ifu #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return addr[31:0] ^ addr[63:32] ^ 32'h5A3C_0013;
    endfunction

    task automatic idle_inputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        tests_run += 5;
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL reset_req got %b want 1", imem_req_o); end
        if (imem_addr_o !== RPC) begin tests_failed++; $display("FAIL reset_addr got %h want %h", imem_addr_o, RPC); end
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid_o); end
        if (pc_o !== RPC) begin tests_failed++; $display("FAIL reset_pc got %h want %h", pc_o, RPC); end
        if (inst_o !== 32'h0) begin tests_failed++; $display("FAIL reset_inst got %h want 0", inst_o); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_fetch();
        imem_gnt_i = 1'b1;
        ready_i    = 1'b1;
        #1;
        tests_run++;
        if (imem_addr_o !== RPC) begin tests_failed++; $display("FAIL basic_addr got %h want %h", imem_addr_o, RPC); end
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0013;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL basic_wait_req got %b want 0", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        tests_run += 3;
        if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got %b want 1", valid_o); end
        if (pc_o !== RPC) begin tests_failed++; $display("FAIL basic_pc got %h want %h", pc_o, RPC); end
        if (inst_o !== 32'h13) begin tests_failed++; $display("FAIL basic_inst got %h want 00000013", inst_o); end
        tick();
        ready_i = 1'b0;
        #1;
        tests_run += 3;
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL basic_next_req got %b want 1", imem_req_o); end
        if (imem_addr_o !== RPC + 64'd4) begin tests_failed++; $display("FAIL basic_next_addr got %h want %h", imem_addr_o, RPC + 64'd4); end
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_next_valid got %b want 0", valid_o); end
        $display("[TB] test_basic_fetch done");
    endtask

    task automatic test_stall();
        logic [31:0] word;
        word       = $urandom;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word;
        tick();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (valid_o !== 1'b1 || pc_o !== RPC + 64'd4 || inst_o !== word || imem_req_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cyc %0d got v=%b pc=%h inst=%h req=%b want v=1 pc=%h inst=%h req=0",
                         i, valid_o, pc_o, inst_o, imem_req_o, RPC + 64'd4, word);
            end
            tick();
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        #1;
        tests_run++;
        if (imem_addr_o !== RPC + 64'd8) begin tests_failed++; $display("FAIL stall_next_addr got %h want %h", imem_addr_o, RPC + 64'd8); end
        $display("[TB] test_stall done");
    endtask

    task automatic test_redirect_wait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_1000;
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end
            #1;
            tests_run++;
            if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL redir_wait_valid cyc %0d got %b want 0", i, valid_o); end
            tick();
        end
        imem_rvalid_i = 1'b0;
        #1;
        tests_run += 3;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL redir_wait_drop got %b want 0", valid_o); end
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL redir_wait_req got %b want 1", imem_req_o); end
        if (imem_addr_o !== 64'h8000_1000) begin tests_failed++; $display("FAIL redir_wait_addr got %h want 0000000080001000", imem_addr_o); end
        $display("[TB] test_redirect_wait done");
    endtask

    task automatic test_redirect_ready();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0093;
        tick();
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_0203;
        ready_i       = 1'b1;
        tick();
        redirect_i = 1'b0;
        ready_i    = 1'b0;
        #1;
        tests_run += 3;
        if (imem_addr_o !== 64'h8000_0200) begin tests_failed++; $display("FAIL redir_ready_addr got %h want 0000000080000200", imem_addr_o); end
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL redir_ready_req got %b want 1", imem_req_o); end
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL redir_ready_valid got %b want 0", valid_o); end
        $display("[TB] test_redirect_ready done");
    endtask

    task automatic test_redirect_req();
        imem_gnt_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_0400;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL redir_req_suppress got %b want 0", imem_req_o); end
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b0;
        #1;
        tests_run += 2;
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL redir_req_next got %b want 1", imem_req_o); end
        if (imem_addr_o !== 64'h8000_0400) begin tests_failed++; $display("FAIL redir_req_addr got %h want 0000000080000400", imem_addr_o); end
        $display("[TB] test_redirect_req done");
    endtask

    task automatic test_reset_midwait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_i      = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        tests_run += 4;
        if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL rst_wait_req got %b want 1", imem_req_o); end
        if (imem_addr_o !== RPC) begin tests_failed++; $display("FAIL rst_wait_addr got %h want %h", imem_addr_o, RPC); end
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_valid got %b want 0", valid_o); end
        if (inst_o !== 32'h0) begin tests_failed++; $display("FAIL rst_wait_inst got %h want 0", inst_o); end
        $display("[TB] test_reset_midwait done");
    endtask

    // Architectural view: the instruction stream must start at the reset PC, step by 4
    // after each accepted instruction and restart at the aligned target after a redirect;
    // every presented word must be the memory content at its PC.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] fetch_addr;
        logic [63:0] targets[4];
        bit          outstanding;
        int          delay;
        int          handshakes;
        int          redirects;
        targets[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        targets[1] = 64'h0000_0000_8000_0003;
        targets[2] = 64'h0000_0000_0000_0001;
        targets[3] = 64'h1234_5678_9ABC_DEF2;
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        exp_pc      = RPC;
        outstanding = 1'b0;
        delay       = 0;
        fetch_addr  = '0;
        handshakes  = 0;
        redirects   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redirect_i    = ($urandom_range(0, 11) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? targets[$urandom_range(0, 3)]
                                                       : {32'h0, $urandom};
            ready_i       = ($urandom_range(0, 9) < 7);
            imem_gnt_i    = ($urandom_range(0, 9) < 6);
            imem_rvalid_i = outstanding && (delay == 0);
            imem_rdata_i  = imem_rvalid_i ? mem_word(fetch_addr) : 32'($urandom);
            #1;
            tests_run++;
            if (outstanding && (imem_req_o || valid_o)) begin
                tests_failed++;
                $display("FAIL rnd_outstanding cyc %0d got req=%b valid=%b want 0/0", cyc, imem_req_o, valid_o);
            end
            if (redirect_i && imem_req_o) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd_req_on_redirect cyc %0d got 1 want 0", cyc);
            end
            if (imem_req_o && imem_gnt_i) begin
                tests_run++;
                if (imem_addr_o !== exp_pc) begin
                    tests_failed++;
                    $display("FAIL rnd_fetch_addr cyc %0d got %h want %h", cyc, imem_addr_o, exp_pc);
                end
                fetch_addr  = imem_addr_o;
                outstanding = 1'b1;
                delay       = $urandom_range(0, 3);
            end else if (imem_rvalid_i) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                delay--;
            end
            if (valid_o) begin
                tests_run++;
                if (pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL rnd_present cyc %0d got pc=%h inst=%h want pc=%h inst=%h",
                             cyc, pc_o, inst_o, exp_pc, mem_word(exp_pc));
                end
            end
            if (redirect_i) begin
                exp_pc = redirect_pc_i & ~64'd3;
                redirects++;
            end else if (valid_o && ready_i) begin
                exp_pc = exp_pc + 64'd4;
                handshakes++;
            end
            tick();
        end
        idle_inputs();
        tests_run++;
        if (handshakes < 300) begin
            tests_failed++;
            $display("FAIL rnd_progress got %0d handshakes want >= 300", handshakes);
        end
        $display("[TB] test_random done: %0d handshakes, %0d redirects", handshakes, redirects);
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_redirect_req();
        test_reset_midwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
